// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned ILEN         = 32;

  // One buffered fetch result at the default address width.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN-1:0]         data;
    logic                    half;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Single-clock FIFO holding fetched words until decode consumes them.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  // Flush overrides any same-cycle push or pop.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_push = push & ~flush;
    do_pop  = pop & ~empty & ~flush;
    head    = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: issues word fetches, tracks in-flight requests,
// drops responses made stale by redirects and buffers the rest.
module pc_fetch_gen
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter int unsigned      DEPTH     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            bj_en,
  input  logic [XLEN-1:0] bj_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_data,
  output logic            out_half
);

  localparam int unsigned     CW       = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] RESET_PC = RESET_VEC & ~XLEN'(3);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] data;
    logic            half;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic            half_pend;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     used;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] aligned;
  logic            req_fire;
  logic            stale;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  entry_t          push_entry;
  entry_t          head;

  // Redirect selection, credit check and response classification.
  always_comb begin
    redirect     = trap_en | bj_en;
    target       = (trap_en ? trap_pc : bj_pc) & ~XLEN'(1);
    aligned      = target & ~XLEN'(3);
    used         = {1'b0, inflight} + {1'b0, fifo_count};
    req_valid    = (used < (CW+1)'(DEPTH));
    req_addr     = fetch_pc;
    req_fire     = req_valid & req_ready;
    inflight_nxt = inflight + CW'(req_fire) - CW'(resp_valid);
    stale        = redirect | (drop_cnt != '0);
    push         = resp_valid & ~stale;
    pop          = out_valid & out_ready;
    push_entry   = '{pc: resp_pc, data: resp_data, half: half_pend};
    out_valid    = ~fifo_empty;
    out_pc       = head.pc;
    out_data     = head.data;
    out_half     = head.half;
  end

  // Request address: redirect wins over sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= aligned;
    else if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
  end

  // Outstanding-request and stale-response counters. On redirect every
  // request still outstanding after this edge belongs to the old stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect)                         drop_cnt <= inflight_nxt;
      else if (resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // PC label and halfword flag attached to the next accepted response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_pc   <= RESET_PC;
      half_pend <= RESET_VEC[1];
    end else if (redirect) begin
      resp_pc   <= aligned;
      half_pend <= target[1];
    end else if (push) begin
      resp_pc   <= resp_pc + XLEN'(4);
      half_pend <= 1'b0;
    end
  end

  // The credit rule keeps the buffer from ever being pushed while full.
  always_ff @(posedge clk) begin
    if (rst_n && !redirect) assert (!(push && fifo_full && !pop));
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Scoreboard bench for pc_fetch_gen with a randomised memory and decode side.
module tb_pc_fetch_gen;

  localparam int unsigned XLEN  = 64;
  localparam logic [63:0] RV    = 64'h1000;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_en = 1'b0;
  logic [63:0] trap_pc = '0;
  logic        bj_en = 1'b0;
  logic [63:0] bj_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_data;
  logic        out_half;

  always #5 clk = ~clk;

  pc_fetch_gen #(
    .XLEN      (XLEN),
    .RESET_VEC (RV),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trap_en    (trap_en),
    .trap_pc    (trap_pc),
    .bj_en      (bj_en),
    .bj_pc      (bj_pc),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_data   (out_data),
    .out_half   (out_half)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
    logic        half;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        expq[$];
  logic [63:0] pend[$];
  int          p_ready = 100;
  int          p_resp  = 100;
  int          p_out   = 100;
  bit          last_fire;

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h1000) return 32'hA;
    if (a == 64'h1004) return 32'hB;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0001;
  endfunction

  function automatic bit chance(input int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: reference model of the fetch stream, judged once per clock.
  initial begin : monitor
    logic [63:0] m_fetch;
    logic        m_half;
    logic        redir;
    logic [63:0] tgt;
    exp_t        e;
    m_fetch = RV & ~64'h3;
    m_half  = RV[1];
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_fetch = RV & ~64'h3;
        m_half  = RV[1];
        expq.delete();
      end else begin
        redir = trap_en | bj_en;
        tgt   = (trap_en ? trap_pc : bj_pc) & ~64'h1;
        if (req_valid && req_ready) begin
          chk("req_addr", req_addr, m_fetch);
          if (!redir) begin
            expq.push_back('{m_fetch, mem_word(m_fetch), m_half});
            m_half  = 1'b0;
            m_fetch = m_fetch + 64'd4;
          end
        end
        if (out_valid && out_ready && !redir) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected actual pc=%h data=%h expected no word", out_pc, out_data);
          end else begin
            e = expq.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_data", {32'b0, out_data}, {32'b0, e.data});
            chk("out_half", {63'b0, out_half}, {63'b0, e.half});
          end
        end
        if (redir) begin
          expq.delete();
          m_fetch = tgt & ~64'h3;
          m_half  = tgt[1];
        end
      end
    end
  end

  // One clock of the memory/decode environment.
  task automatic step();
    bit          fire;
    bit          got;
    logic [63:0] addr;
    @(negedge clk);
    fire = rst_n && req_valid && req_ready;
    got  = rst_n && resp_valid;
    addr = req_addr;
    @(posedge clk);
    #1;
    last_fire = fire;
    if (got && pend.size() > 0) void'(pend.pop_front());
    if (fire) pend.push_back(addr);
    resp_valid = (pend.size() > 0) && chance(p_resp);
    resp_data  = resp_valid ? mem_word(pend[0]) : $urandom;
    req_ready  = chance(p_ready);
    out_ready  = chance(p_out);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    trap_en    = 1'b0;
    bj_en      = 1'b0;
    resp_valid = 1'b0;
    pend.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_out(input string name, input int limit);
    for (int i = 0; i < limit && !out_valid; i++) step();
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s actual=timeout expected=out_valid within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_req(input string name, input int limit);
    for (int i = 0; i < limit && !req_valid; i++) step();
    if (!req_valid) begin
      checks++;
      errors++;
      $display("FAIL %s actual=timeout expected=req_valid within %0d cycles", name, limit);
    end
  endtask

  // Stimulus: directed scenarios followed by a randomised soak.
  initial begin : driver
    int nf;
    do_reset();
    chk("rst_req_valid", {63'b0, req_valid}, 64'd1);
    chk("rst_req_addr", req_addr, 64'h1000);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);

    // Straight-line fetch with an always-ready memory and decoder.
    p_ready = 100; p_resp = 100; p_out = 100;
    req_ready = 1'b1; out_ready = 1'b1;
    step();
    chk("a_req_addr2", req_addr, 64'h1004);
    step();
    chk("a_out_valid", {63'b0, out_valid}, 64'd1);
    chk("a_out_pc0", out_pc, 64'h1000);
    chk("a_out_data0", {32'b0, out_data}, 64'hA);
    chk("a_out_half0", {63'b0, out_half}, 64'd0);
    step();
    chk("a_out_pc1", out_pc, 64'h1004);
    chk("a_out_data1", {32'b0, out_data}, 64'hB);
    repeat (8) step();

    // Decoder stall: credits run out after DEPTH requests.
    do_reset();
    p_out = 0; out_ready = 1'b0; req_ready = 1'b1;
    nf = 0;
    repeat (10) begin
      step();
      nf += int'(last_fire);
    end
    chk("b_fires", 64'(nf), 64'(DEPTH));
    chk("b_req_valid_stalled", {63'b0, req_valid}, 64'd0);
    p_out = 100; out_ready = 1'b1;
    step();
    chk("b_req_valid_after_pop", {63'b0, req_valid}, 64'd1);
    repeat (6) step();

    // Branch to a halfword target with two requests outstanding.
    do_reset();
    p_resp = 0; p_out = 0; resp_valid = 1'b0; out_ready = 1'b0; req_ready = 1'b1;
    step();
    step();
    chk("c_req_valid_full", {63'b0, req_valid}, 64'd0);
    bj_en = 1'b1; bj_pc = 64'h2002;
    p_resp = 100; p_out = 100;
    step();
    bj_en = 1'b0;
    chk("c_req_addr", req_addr, 64'h2000);
    wait_out("c_first_out", 30);
    chk("c_out_pc0", out_pc, 64'h2000);
    chk("c_out_half0", {63'b0, out_half}, 64'd1);
    step();
    wait_out("c_second_out", 30);
    chk("c_out_pc1", out_pc, 64'h2004);
    chk("c_out_half1", {63'b0, out_half}, 64'd0);
    repeat (6) step();

    // Trap outranks a simultaneous branch.
    trap_en = 1'b1; trap_pc = 64'h80; bj_en = 1'b1; bj_pc = 64'h40;
    step();
    trap_en = 1'b0; bj_en = 1'b0;
    chk("d_req_addr", req_addr, 64'h80);
    repeat (8) step();

    // Address wrap at the top of the address space.
    bj_en = 1'b1; bj_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    bj_en = 1'b0;
    wait_req("e_wait_top", 30);
    chk("e_req_addr_top", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    wait_req("e_wait_wrap", 30);
    chk("e_req_addr_wrap", req_addr, 64'h0);
    repeat (8) step();

    // Asynchronous reset in the middle of traffic.
    rst_n = 1'b0;
    #2;
    chk("f_async_out_valid", {63'b0, out_valid}, 64'd0);
    chk("f_async_req_addr", req_addr, 64'h1000);
    chk("f_async_req_valid", {63'b0, req_valid}, 64'd1);
    do_reset();

    // Randomised traffic with occasional redirects.
    p_ready = 70; p_resp = 60; p_out = 70;
    repeat (4000) begin
      if (chance(4)) begin
        trap_en = chance(50);
        bj_en   = trap_en ? chance(50) : 1'b1;
        trap_pc = {$urandom, $urandom};
        bj_pc   = {$urandom, $urandom};
        if (chance(25)) trap_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        if (chance(25)) bj_pc   = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      end
      step();
      trap_en = 1'b0;
      bj_en   = 1'b0;
    end
    p_ready = 0; p_resp = 100; p_out = 100;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_gen.md
PC_FETCH_GEN -- requirements
Module: pc_fetch_gen

Interface
REQ-001 Parameter XLEN, default 64: PC and address width.
REQ-002 Parameter RESET_VEC, default 0: first fetch PC after reset; bit0 is 0.
REQ-003 Parameter DEPTH, default 2: power of two, at least 2; maximum words in flight plus buffered.
REQ-004 Port list, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- trap_en  in  1  trap redirect.
- trap_pc  in  XLEN  trap target.
- bj_en  in  1  branch/jump redirect.
- bj_pc  in  XLEN  branch/jump target.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts the request.
- req_addr  out  XLEN  word-aligned fetch address; bits [1:0] are 0.
- resp_valid  in  1  in-order 32-bit response; arrives at least 1 cycle after acceptance.
- resp_data  in  32  fetched word.
- out_valid  out  1  buffered word available to decode.
- out_ready  in  1  decode consumes the word; low means stall.
- out_pc  out  XLEN  word address of out_data.
- out_data  out  32  fetched word.
- out_half  out  1  first valid halfword is the upper one (redirect target bit1 was 1).

Function
REQ-005 Redirect priority: trap_en over bj_en. redirect = trap_en | bj_en. target = the selected pc with bit0 forced to 0.
REQ-006 fetch_pc register: on redirect, loads target with bits [1:0] cleared; otherwise advances by 4 on each req fire (req_valid & req_ready).
REQ-007 req_addr equals fetch_pc.
REQ-008 req_valid = (inflight + fifo_count) < DEPTH; it is not gated by redirect.
REQ-009 inflight counter: +1 on req fire, -1 on resp_valid; both in the same cycle leaves it unchanged.
REQ-010 drop_cnt, the stale-response counter: on redirect, loads inflight + req fire - resp_valid. Otherwise it decrements on each resp_valid while it is nonzero.
REQ-011 A response is stale if drop_cnt > 0 or redirect is asserted that cycle. Stale responses are discarded and never enter the FIFO.
REQ-012 Non-stale response: pushes {resp_pc, resp_data, half_pend} into the FIFO; resp_pc += 4; half_pend <= 0.
REQ-013 On redirect: resp_pc <= target & ~3; half_pend <= target[1]. The FIFO is flushed; a same-cycle pop is ignored.
REQ-014 out_* presents the FIFO head; pop on out_valid & out_ready.
REQ-015 Simultaneous push and pop on a full FIFO is legal. The credit rule in REQ-008 guarantees no overflow; a push while full is an assertion failure.
REQ-016 Latency: response to out_valid is 1 cycle (registered FIFO). Redirect to first req_valid at the new address is 1 cycle.
REQ-017 Counter widths are $clog2(DEPTH)+1. Address arithmetic wraps modulo 2^XLEN.

Reset
REQ-018 On rst_n low, asynchronously: fetch_pc = RESET_VEC & ~3; resp_pc = RESET_VEC & ~3; half_pend = RESET_VEC[1].
REQ-019 On rst_n low, asynchronously: inflight, drop_cnt and the FIFO are cleared, so out_valid = 0.
REQ-020 After reset, req_valid is 1 in the first cycle. Reset mid-transaction abandons in-flight requests; the memory side is reset together.

Structure
REQ-021 Shared package fetch_pkg holds XLEN_DEFAULT, ILEN (32) and the fetch entry struct {pc, data, half}.
REQ-022 The buffer is one sub-module, fetch_fifo: synchronous, parametrised on DEPTH and entry type, with push, pop, flush, count, full and empty.

Verification
REQ-023 Reset with RESET_VEC=0x1000, req_ready=1, responses 0xA,0xB: req_addr 0x1000 then 0x1004; out_pc 0x1000/0xA then 0x1004/0xB; out_half=0.
REQ-024 out_ready=0 with DEPTH=2: exactly 2 requests issue, then req_valid=0 until the first pop.
REQ-025 bj_en with bj_pc=0x2002 while 2 requests are in flight: both old responses are dropped; next req_addr is 0x2000; first out_pc is 0x2000 with out_half=1, then 0x2004 with out_half=0.
REQ-026 trap_en (trap_pc=0x80) and bj_en (bj_pc=0x40) in the same cycle: next req_addr is 0x80.
REQ-027 Redirect in the same cycle as a req fire and resp_valid: drop_cnt equals inflight; no stale word appears on out_*.
REQ-028 fetch_pc=0xFFFF_FFFF_FFFF_FFFC with XLEN=64: the next req_addr wraps to 0x0.
